sha256_msg_sched: RTL and testbench
===================================

Name: sha256_msg_sched

Overview:
SHA-256 message-schedule generator, the producer side of the W-word interface consumed by the compression round (the round logic that applies Σ0/Σ1, Ch and Maj).
- Accepts one 512-bit block over a valid/ready handshake.
- Streams the 64 schedule words W0..W63 one per transfer over a second valid/ready handshake.
- Uses a 16-word sliding window with combinational σ0/σ1 on the feedback path.
- Sits between the midstate/nonce block builder and the round datapath of the miner core.

Parameters:
- WORDS, 64, number of schedule words emitted per block; fixed by the algorithm and not overridable in practice.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- blk_valid  in  1  input block valid.
- blk_ready  out  1  block can be accepted.
- blk_data  in  512  message block; W0 = blk_data[511:480], W15 = blk_data[31:0].
- flush  in  1  synchronous abort; returns the block to IDLE.
- w_valid  out  1  schedule word valid.
- w_ready  in  1  consumer ready.
- w_data  out  32  schedule word W_t (or W_t+K_t, see Optional Feature).
- w_idx  out  6  round index t of w_data.
- w_last  out  1  high when w_idx = 63 and w_valid = 1.

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE; window cleared to 0; counter = 0.
  - Output reset values: blk_ready = 1, w_valid = 0, w_data = 0, w_idx = 0, w_last = 0.
- States:
  - IDLE: blk_ready = 1, w_valid = 0.
  - RUN: blk_ready = 0, w_valid = 1.
- IDLE -> RUN on blk_valid && blk_ready.
  - The 16 words are loaded into window[0..15] (window[i] = W_i) and the counter is set to 0.
  - w_valid rises in the next cycle, so latency from block accept to first word is 1 cycle.
- In RUN:
  - w_data = window[0] (combinationally, or + K_t if the feature is enabled); w_idx = counter.
  - On a transfer (w_valid && w_ready):
    - Shift the window down: window[i] <= window[i+1] for i = 0..14.
    - Load window[15] <= σ1(window[14]) + window[9] + σ0(window[1]) + window[0], all additions mod 2^32.
    - Increment the counter.
  - σ0(x) = ROTR7 ^ ROTR18 ^ SHR3. σ1(x) = ROTR17 ^ ROTR19 ^ SHR10.
  - Words generated beyond W63 are don't-care and never emitted.
- Transfer with counter = 63 (w_last = 1): state -> IDLE, w_valid falls the next cycle, and blk_ready = 1 from that cycle.
  - There is no same-cycle back-to-back load, so there is a minimum of 1 idle cycle between blocks.
- Backpressure: while w_valid && !w_ready, w_data, w_idx and w_last hold stable and the window does not shift. There is no timeout.
- blk_valid while in RUN is ignored; blk_ready = 0 in RUN.
- flush:
  - In RUN: next state is IDLE, counter = 0, w_valid = 0 the next cycle; any transfer in the flush cycle is discarded.
  - flush has priority over a transfer, including on the w_last transfer.
  - In IDLE, flush has priority over blk_valid: the block is not accepted and blk_ready stays 1.
- rst_n asserted mid-block: immediate return to the reset values; the partial stream is abandoned.
- Throughput: one word per cycle with w_ready held high, so 64 data cycles + 1 idle cycle per block.

Optional Feature:
- Macro: SHA256_SCHED_KADD_EN.
- Defined:
  - An internal 64-entry K constant ROM indexed by counter is instantiated.
  - w_data = window[0] + K[counter] mod 2^32, pre-adding the round constant so the round datapath saves one adder.
  - w_data is still combinational from registered state, with no extra latency.
- Undefined: no ROM; w_data = raw W_t.
- Handshake, w_idx and w_last are identical in both builds.

Test Plan:
- Reset values: hold rst_n low, release -> blk_ready = 1, w_valid = 0, w_data = 0, w_idx = 0.
- Raw schedule, "abc" padded block, feature off, w_ready = 1: blk_data words W0 = 0x61626380, W1..W14 = 0, W15 = 0x00000018.
  - Expect the first word 1 cycle after accept: W0 = 0x61626380 (idx 0), W15 = 0x00000018 (idx 15).
  - Then W16 = 0x61626380, W17 = 0x000F0000, W18 = 0x7DA86405, W19 = 0x600003C6.
  - w_last only on idx 63; blk_ready = 1 the cycle after.
- Backpressure: same block, drop w_ready for 5 cycles at idx 17 -> w_data holds 0x000F0000 and idx holds 17 throughout; stream resumes with W18 = 0x7DA86405; the full 64-word stream matches the golden model.
- Block refused in RUN and flush: pulse blk_valid with a different block at idx 30 -> ignored, stream unchanged. Assert flush at idx 40 with w_ready = 1 -> idx 40 is the last word seen, w_valid = 0 next cycle, blk_ready = 1; a new block then restarts at idx 0.
- Async reset mid-stream: drop rst_n at idx 20 (between clock edges) -> w_valid = 0 and w_idx = 0 immediately, without waiting for a clock edge.
- SHA256_SCHED_KADD_EN build: "abc" block -> idx 0 w_data = 0xA3EC9318 (0x61626380 + 0x428A2F98); idx 1 w_data = 0x71374491 (0 + K1); all 64 words equal W_t + K_t from the golden model.

Source files
------------

// File: rtl/sha256_msg_sched.sv
// SHA-256 message-schedule generator.
//
// Accepts one 512-bit block over a valid/ready handshake. It then streams the 64 schedule
// words W0..W63, one per transfer, over a second valid/ready handshake.
// A 16-word sliding window holds W_t..W_t+15. The word entering the window is built from
// combinational sigma0/sigma1 of the current window contents.
//
// Optional build macro: SHA256_SCHED_KADD_EN
//   When this macro is defined, w_data_o carries W_t + K_t (mod 2^32), which saves the
//   round datapath one adder. When it is undefined, w_data_o carries the raw W_t.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   blk_valid_i  input block valid
//   blk_ready_o  block can be accepted (IDLE)
//   blk_data_i   message block, W0 = [511:480] .. W15 = [31:0]
//   flush_i      synchronous abort back to IDLE (beats transfer and block accept)
//   w_valid_o    schedule word valid (RUN)
//   w_ready_i    consumer ready
//   w_data_o     schedule word W_t (or W_t + K_t)
//   w_idx_o      round index t
//   w_last_o     high with the t = 63 word
module sha256_msg_sched #(
  parameter int unsigned WORDS = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         blk_valid_i,
  output logic         blk_ready_o,
  input  logic [511:0] blk_data_i,
  input  logic         flush_i,
  output logic         w_valid_o,
  input  logic         w_ready_i,
  output logic [31:0]  w_data_o,
  output logic [5:0]   w_idx_o,
  output logic         w_last_o
);

  localparam logic [5:0] LastIdx = 6'(WORDS - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e      state_q;
  logic [5:0]  cnt_q;
  logic [31:0] win_q [16];
  logic [31:0] fb_word;

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

`ifdef SHA256_SCHED_KADD_EN
  localparam logic [31:0] KRom [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
`endif

  // Word entering the window: W_t+16 = s1(W_t+14) + W_t+9 + s0(W_t+1) + W_t.
  always_comb begin
    fb_word = ssig1(win_q[14]) + win_q[9] + ssig0(win_q[1]) + win_q[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      for (int i = 0; i < 16; i++) win_q[i] <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!flush_i && blk_valid_i) begin
            state_q <= StRun;
            cnt_q   <= '0;
            for (int i = 0; i < 16; i++) win_q[i] <= blk_data_i[511 - 32*i -: 32];
          end
        end
        StRun: begin
          if (flush_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else if (w_ready_i) begin
            for (int i = 0; i < 15; i++) win_q[i] <= win_q[i+1];
            win_q[15] <= fb_word;
            // Wraps to 0 after the last word, so w_idx reads 0 again in IDLE.
            cnt_q     <= cnt_q + 6'd1;
            if (cnt_q == LastIdx) state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    blk_ready_o = (state_q == StIdle);
    w_valid_o   = (state_q == StRun);
    w_idx_o     = cnt_q;
    w_last_o    = w_valid_o && (cnt_q == LastIdx);
    // Data is forced to 0 outside RUN so idle and reset values do not depend on the build.
    w_data_o    = '0;
    if (w_valid_o) begin
`ifdef SHA256_SCHED_KADD_EN
      w_data_o = win_q[0] + KRom[cnt_q];
`else
      w_data_o = win_q[0];
`endif
    end
  end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Self-checking bench for sha256_msg_sched.
// The reference model is the textbook W_t recurrence over a 64-entry array. A scoreboard
// queue is filled when a block is issued, and a negedge monitor drains the queue on every
// accepted word.
module tb_sha256_msg_sched;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         flush;
  logic         w_valid;
  logic         w_ready;
  logic [31:0]  w_data;
  logic [5:0]   w_idx;
  logic         w_last;

  always #5 clk = ~clk;

  sha256_msg_sched dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .blk_valid_i (blk_valid),
    .blk_ready_o (blk_ready),
    .blk_data_i  (blk_data),
    .flush_i     (flush),
    .w_valid_o   (w_valid),
    .w_ready_i   (w_ready),
    .w_data_o    (w_data),
    .w_idx_o     (w_idx),
    .w_last_o    (w_last)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [5:0]  idx;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [31:0] gold [64];

`ifdef SHA256_SCHED_KADD_EN
  logic [31:0] k_tab [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
    32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
    32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
    32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
    32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
    32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
`endif

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic build_gold(input logic [511:0] blk);
    logic [31:0] w [64];
    for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++) w[t] = s1(w[t-2]) + w[t-7] + s0(w[t-15]) + w[t-16];
    for (int t = 0; t < 64; t++) begin
`ifdef SHA256_SCHED_KADD_EN
      gold[t] = w[t] + k_tab[t];
`else
      gold[t] = w[t];
`endif
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int n);
    exp_t e;
    for (int t = 0; t < n; t++) begin
      e.data = gold[t];
      e.idx  = 6'(t);
      e.last = (t == 63);
      exp_q.push_back(e);
    end
  endtask

  // Monitor: a word is consumed at the coming posedge iff valid && ready && !flush now.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && w_valid && w_ready && !flush) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_word: got idx %0d data %h, expected none", w_idx, w_data);
        end else begin
          e = exp_q.pop_front();
          check("w_data", w_data, e.data);
          check("w_idx", 32'(w_idx), 32'(e.idx));
          check("w_last", 32'(w_last), 32'(e.last));
        end
      end
    end
  end

  // Stimulus tasks start and end at posedge + 1.
  task automatic load_block(input logic [511:0] blk, input int n_exp);
    bit done = 0;
    build_gold(blk);
    push_exp(n_exp);
    blk_data  = blk;
    blk_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (blk_ready) done = 1;
      @(posedge clk);
      #1;
    end
    blk_valid = 1'b0;
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL block_accept: got no accept, expected blk_ready within 20 cycles");
    end
  endtask

  task automatic wait_idx(input int idx);
    bit hit = 0;
    for (int i = 0; i < 400 && !hit; i++) begin
      if (w_valid && w_idx == 6'(idx)) hit = 1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    if (!hit) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_idx: got no word with idx %0d, expected it within 400 cycles", idx);
    end
  endtask

  // Runs the stream to completion (optionally with random ready), then checks the idle state.
  task automatic finish_stream(input bit rand_ready);
    int guard = 0;
    while (w_valid && guard < 1000) begin
      if (rand_ready) w_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      guard++;
    end
    w_ready = 1'b1;
    if (guard >= 1000) begin
      n_cmp++;
      n_fail++;
      $display("FAIL stream_end: got w_valid still high, expected end within 1000 cycles");
    end
    @(negedge clk);
    check("idle_blk_ready", 32'(blk_ready), 32'd1);
    check("idle_w_valid", 32'(w_valid), 32'd0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[511 - 32*i -: 32] = $urandom();
    return b;
  endfunction

  logic [511:0] abc_blk;

  initial begin
    int guard;
    abc_blk   = {32'h61626380, 448'h0, 32'h00000018};
    rst_n     = 1'b0;
    blk_valid = 1'b0;
    blk_data  = '0;
    flush     = 1'b0;
    w_ready   = 1'b1;

    // Reset values.
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_blk_ready", 32'(blk_ready), 32'd1);
    check("rst_w_valid", 32'(w_valid), 32'd0);
    check("rst_w_data", w_data, 32'd0);
    check("rst_w_idx", 32'(w_idx), 32'd0);
    check("rst_w_last", 32'(w_last), 32'd0);
    @(posedge clk);
    #1;

    // "abc" block, w_ready high, with known-answer spot checks.
    load_block(abc_blk, 64);
    @(negedge clk);
    check("latency_valid", 32'(w_valid), 32'd1);
    check("latency_idx", 32'(w_idx), 32'd0);
    @(posedge clk);
    #1;
    guard = 0;
    while (w_valid && guard < 100) begin
      @(negedge clk);
`ifdef SHA256_SCHED_KADD_EN
      if (w_idx == 6'd0) check("kadd_w0", w_data, 32'hA3EC9318);
      if (w_idx == 6'd1) check("kadd_w1", w_data, 32'h71374491);
`else
      if (w_idx == 6'd15) check("abc_w15", w_data, 32'h00000018);
      if (w_idx == 6'd16) check("abc_w16", w_data, 32'h61626380);
      if (w_idx == 6'd17) check("abc_w17", w_data, 32'h000F0000);
      if (w_idx == 6'd18) check("abc_w18", w_data, 32'h7DA86405);
      if (w_idx == 6'd19) check("abc_w19", w_data, 32'h600003C6);
`endif
      @(posedge clk);
      #1;
      guard++;
    end
    finish_stream(1'b0);

    // Backpressure at idx 17 for 5 cycles.
    load_block(abc_blk, 64);
    wait_idx(17);
    w_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("bp_hold_data", w_data, gold[17]);
      check("bp_hold_idx", 32'(w_idx), 32'd17);
      check("bp_hold_valid", 32'(w_valid), 32'd1);
      @(posedge clk);
      #1;
    end
    w_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_resume_idx", 32'(w_idx), 32'd18);
    check("bp_resume_data", w_data, gold[18]);
    @(posedge clk);
    #1;
    finish_stream(1'b0);

    // Block ignored in RUN, then flush at idx 40.
    load_block(rand_block(), 40);
    wait_idx(30);
    blk_data  = rand_block();
    blk_valid = 1'b1;
    @(negedge clk);
    check("run_blk_ready", 32'(blk_ready), 32'd0);
    @(posedge clk);
    #1 blk_valid = 1'b0;
    wait_idx(40);
    flush = 1'b1;
    @(negedge clk);
    check("flush_idx", 32'(w_idx), 32'd40);
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_w_valid", 32'(w_valid), 32'd0);
    check("flush_blk_ready", 32'(blk_ready), 32'd1);
    check("flush_w_idx", 32'(w_idx), 32'd0);
    @(posedge clk);
    #1;

    // Flush in IDLE beats blk_valid.
    blk_data  = rand_block();
    blk_valid = 1'b1;
    flush     = 1'b1;
    @(posedge clk);
    #1;
    blk_valid = 1'b0;
    flush     = 1'b0;
    @(negedge clk);
    check("idle_flush_w_valid", 32'(w_valid), 32'd0);
    check("idle_flush_blk_ready", 32'(blk_ready), 32'd1);
    @(posedge clk);
    #1;

    // New random block after flush, random backpressure.
    load_block(rand_block(), 64);
    finish_stream(1'b1);

    // Async reset mid-stream at idx 20.
    load_block(rand_block(), 20);
    wait_idx(20);
    #2 rst_n = 1'b0;
    #1;
    check("arst_w_valid", 32'(w_valid), 32'd0);
    check("arst_w_idx", 32'(w_idx), 32'd0);
    check("arst_w_data", w_data, 32'd0);
    check("arst_blk_ready", 32'(blk_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_w_valid", 32'(w_valid), 32'd0);
    @(posedge clk);
    #1;

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
